hazard_ctl: RTL and testbench
=============================

# hazard_ctl

Pipeline hazard and stall controller for the 5-stage core. Each cycle it decides whether the IF/ID and ID/EX pipeline registers advance, hold, are flushed, or take a bubble. It covers three cases: load-use hazards, multi-cycle memory wait states and taken-branch flushes. It drives the `stall` input of the ID/EX register, the hold/flush controls of the neighbouring stages, and keeps a stall-cycle performance counter.

## Interface
Parameters:
- FLUSH_CYCLES, 2, number of cycles a taken branch flushes IF/ID and bubbles ID/EX (legal range 1–15).
- WAIT_TIMEOUT, 255, consecutive MEM_WAIT cycles before the controller declares a fault (legal range 1–255).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_src_top  in  5  ID top-operand register index.
- id_src_bot  in  5  ID bottom-operand register index.
- id_uses_top  in  1  ID instruction reads id_src_top.
- id_uses_bot  in  1  ID instruction reads id_src_bot.
- ex_load  in  1  EX instruction is a memory load that writes the register file.
- ex_dest  in  5  EX destination register index.
- branch_taken  in  1  EX resolved a taken branch, call or return.
- mem_req  in  1  MEM stage has a memory access in flight.
- mem_ready  in  1  memory completes the access this cycle.
- pc_hold  out  1  PC does not advance.
- if_id_hold  out  1  IF/ID register keeps its contents.
- if_id_flush  out  1  IF/ID register loads a NOP.
- id_ex_stall  out  1  ID/EX register loads a bubble (all zeros).
- id_ex_hold  out  1  ID/EX register keeps its contents.
- ex_mem_hold  out  1  EX/MEM register keeps its contents.
- mem_fault  out  1  sticky memory-timeout fault flag.
- state  out  2  current FSM state: RUN=0, MEM_WAIT=1, FLUSH=2, FAULT=3.
- stall_cycles  out  16  saturating count of cycles with pc_hold=1.

## Operation
The control outputs are combinational (Mealy) functions of the current state and inputs. The state, the counters and mem_fault are registered.

Terms used below:
- **freeze**: pc_hold=1, if_id_hold=1, id_ex_hold=1, ex_mem_hold=1; if_id_flush=0, id_ex_stall=0.
- **luh** (load-use hazard): ex_load & id_valid & ((id_uses_top & id_src_top==ex_dest) | (id_uses_bot & id_src_bot==ex_dest)). Register index 0 gets no exemption.
- **RUN rules**, applied in priority order:
  1. If mem_req & !mem_ready: freeze; next state MEM_WAIT; wait_cnt cleared to 1.
  2. Else if branch_taken: if_id_flush=1, id_ex_stall=1, PC advances; if FLUSH_CYCLES>1, next state FLUSH with flush_cnt=FLUSH_CYCLES-1, otherwise stay in RUN.
  3. Else if luh: pc_hold=1, if_id_hold=1, id_ex_stall=1 for exactly this cycle.
  4. Else all outputs are 0.

State behaviour:
- **RUN**: apply the RUN rules.
- **MEM_WAIT**:
  - If !mem_ready: freeze and increment wait_cnt. If wait_cnt==WAIT_TIMEOUT, the next state is FAULT.
  - If mem_ready: the freeze is released this cycle, the RUN rules apply this cycle with rule 1 skipped, and the next state follows those rules (RUN or FLUSH).
  - branch_taken is not acted on while frozen. It is re-evaluated on release because EX is held.
- **FLUSH**:
  - If mem_req & !mem_ready: freeze, flush_cnt held, state held.
  - Else if branch_taken: treated as a new branch; flush_cnt reloads to FLUSH_CYCLES-1 and the flush outputs are asserted.
  - Else: if_id_flush=1, id_ex_stall=1, flush_cnt decrements; when flush_cnt reaches 0, the next state is RUN.
  - luh is not evaluated in FLUSH, because ID holds a flushed NOP.
- **FAULT**: freeze permanently and set mem_fault=1. Only reset leaves this state.

Counters:
- stall_cycles increments by 1 in every cycle where pc_hold=1 and saturates at 16'hFFFF.
- wait_cnt is 8 bits.
- flush_cnt is 4 bits.

## Timing
- Reset takes effect on the first rising edge with reset=1: state=RUN, wait_cnt=0, flush_cnt=0, mem_fault=0, stall_cycles=0.
- While reset=1, all control outputs are forced to 0, regardless of the other inputs.
- Reset during MEM_WAIT, FLUSH or FAULT returns to RUN on that edge, with no residual hold or flush.
- Hazard response has zero latency: outputs react in the same cycle as the triggering inputs.
- A load-use hazard costs exactly 1 bubble. The next cycle, EX holds the bubble, so luh=0.
- A branch costs FLUSH_CYCLES bubbles when no memory stall intervenes.
- A memory access with N wait cycles (mem_ready first high on the cycle N+1 after mem_req) holds the pipeline for N cycles, and stall_cycles increases by N.
- Timeout: entering MEM_WAIT followed by WAIT_TIMEOUT cycles of !mem_ready moves the FSM to FAULT; mem_fault is visible on the next cycle.
- Simultaneous branch_taken and luh: the branch wins, with no pc_hold.

## Test plan
- Load-use: ex_load=1, ex_dest=5, id_valid=1, id_uses_bot=1, id_src_bot=5 for one cycle -> pc_hold=1, if_id_hold=1, id_ex_stall=1 for 1 cycle; stall_cycles=1.
- Branch: branch_taken pulse with default parameters -> if_id_flush=1 and id_ex_stall=1 for 2 cycles; state goes 0→2→0; pc_hold stays 0.
- Memory wait: mem_req=1 with mem_ready=0 for 3 cycles, then 1 -> freeze for 3 cycles, released on the 4th; state=1 during the wait; stall_cycles=3.
- Stall inside flush: branch_taken, then in cycle 2 hold mem_req=1, mem_ready=0 for 2 cycles -> freeze for 2 cycles, then one more flush cycle, then RUN (3 flush cycles total).
- Timeout: with WAIT_TIMEOUT=4, hold mem_req=1, mem_ready=0 -> state=3 after 4 wait cycles; mem_fault=1 and outputs stay frozen; asserting reset clears everything to 0.
- Counter saturation: preload by holding a stall for 65540 cycles -> stall_cycles stays at 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctl_if.sv
// hazard_ctl_if: bundle between the 5-stage pipeline and its hazard/stall controller.
//   Pipeline -> controller: ID operand info, EX load/dest, branch resolution, MEM handshake.
//   Controller -> pipeline: PC/IF-ID/ID-EX/EX-MEM hold, flush and bubble controls, fault flag,
//   FSM state and the stall-cycle performance counter.
//   master : the pipeline side (drives the hazard sources, consumes the controls).
//   slave  : the controller side.
interface hazard_ctl_if;
  logic        id_valid;
  logic [4:0]  id_src_top;
  logic [4:0]  id_src_bot;
  logic        id_uses_top;
  logic        id_uses_bot;
  logic        ex_load;
  logic [4:0]  ex_dest;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_hold;
  logic        if_id_hold;
  logic        if_id_flush;
  logic        id_ex_stall;
  logic        id_ex_hold;
  logic        ex_mem_hold;
  logic        mem_fault;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  modport master (
    output id_valid, id_src_top, id_src_bot, id_uses_top, id_uses_bot,
    output ex_load, ex_dest, branch_taken, mem_req, mem_ready,
    input  pc_hold, if_id_hold, if_id_flush, id_ex_stall, id_ex_hold, ex_mem_hold,
    input  mem_fault, state, stall_cycles
  );

  modport slave (
    input  id_valid, id_src_top, id_src_bot, id_uses_top, id_uses_bot,
    input  ex_load, ex_dest, branch_taken, mem_req, mem_ready,
    output pc_hold, if_id_hold, if_id_flush, id_ex_stall, id_ex_hold, ex_mem_hold,
    output mem_fault, state, stall_cycles
  );
endinterface

// File: rtl/hazard_ctl.sv
// hazard_ctl: pipeline hazard and stall controller for the 5-stage core.
//   Decides each cycle whether IF/ID and ID/EX advance, hold, flush or take a bubble, covering
//   load-use hazards, multi-cycle memory waits and taken-branch flushes.
// Ports:
//   clock  - system clock, all state updates on the rising edge
//   reset  - synchronous, active-high; forces all control outputs to 0 while high
//   bus    - hazard_ctl_if.slave: hazard sources in, pipeline controls/status out
// Parameters:
//   FLUSH_CYCLES - bubbles inserted per taken branch (1..15)
//   WAIT_TIMEOUT - consecutive memory wait cycles before declaring a fault (1..255)
module hazard_ctl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input logic         clock,
  input logic         reset,
  hazard_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2,
    StFault   = 2'd3
  } state_e;

  localparam logic [3:0] FlushReload = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WaitLimit   = 8'(WAIT_TIMEOUT);
  localparam bit         MultiFlush  = (FLUSH_CYCLES > 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic        mem_fault_q, mem_fault_d;
  logic [15:0] stall_cnt_q;

  logic pc_hold_c, if_id_hold_c, if_id_flush_c, id_ex_stall_c, id_ex_hold_c, ex_mem_hold_c;
  logic luh, mem_block;
  logic apply_run, allow_mem_stall;

  // Register 0 is deliberately not exempted: the core treats it as an ordinary register.
  assign luh = bus.ex_load & bus.id_valid &
               ((bus.id_uses_top & (bus.id_src_top == bus.ex_dest)) |
                (bus.id_uses_bot & (bus.id_src_bot == bus.ex_dest)));

  assign mem_block = bus.mem_req & ~bus.mem_ready;

  always_comb begin
    pc_hold_c       = 1'b0;
    if_id_hold_c    = 1'b0;
    if_id_flush_c   = 1'b0;
    id_ex_stall_c   = 1'b0;
    id_ex_hold_c    = 1'b0;
    ex_mem_hold_c   = 1'b0;
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    flush_cnt_d     = flush_cnt_q;
    apply_run       = 1'b0;
    allow_mem_stall = 1'b0;

    if (!reset) begin
      unique case (state_q)
        StRun: begin
          apply_run       = 1'b1;
          allow_mem_stall = 1'b1;
        end

        StMemWait: begin
          if (!bus.mem_ready) begin
            pc_hold_c    = 1'b1;
            if_id_hold_c = 1'b1;
            id_ex_hold_c = 1'b1;
            ex_mem_hold_c = 1'b1;
            if (wait_cnt_q == WaitLimit) begin
              state_d = StFault;
            end else begin
              wait_cnt_d = wait_cnt_q + 8'd1;
            end
          end else begin
            // Release: EX was held, so a pending branch or hazard is re-evaluated now.
            apply_run = 1'b1;
            state_d   = StRun;
          end
        end

        StFlush: begin
          if (mem_block) begin
            pc_hold_c     = 1'b1;
            if_id_hold_c  = 1'b1;
            id_ex_hold_c  = 1'b1;
            ex_mem_hold_c = 1'b1;
          end else begin
            // ID holds a flushed NOP here, so load-use is never considered.
            if_id_flush_c = 1'b1;
            id_ex_stall_c = 1'b1;
            if (bus.branch_taken) begin
              flush_cnt_d = FlushReload;
            end else begin
              flush_cnt_d = flush_cnt_q - 4'd1;
            end
            if (flush_cnt_d == 4'd0) begin
              state_d = StRun;
            end
          end
        end

        StFault: begin
          pc_hold_c     = 1'b1;
          if_id_hold_c  = 1'b1;
          id_ex_hold_c  = 1'b1;
          ex_mem_hold_c = 1'b1;
        end

        default: begin
          state_d = StRun;
        end
      endcase

      // Shared RUN priority rules; the memory-stall rule is skipped on a MEM_WAIT release.
      if (apply_run) begin
        if (allow_mem_stall && mem_block) begin
          pc_hold_c     = 1'b1;
          if_id_hold_c  = 1'b1;
          id_ex_hold_c  = 1'b1;
          ex_mem_hold_c = 1'b1;
          state_d       = StMemWait;
          wait_cnt_d    = 8'd1;
        end else if (bus.branch_taken) begin
          if_id_flush_c = 1'b1;
          id_ex_stall_c = 1'b1;
          if (MultiFlush) begin
            state_d     = StFlush;
            flush_cnt_d = FlushReload;
          end
        end else if (luh) begin
          pc_hold_c     = 1'b1;
          if_id_hold_c  = 1'b1;
          id_ex_stall_c = 1'b1;
        end
      end
    end
  end

  // Fault flag rises on the edge that enters FAULT, so it appears together with state=FAULT.
  assign mem_fault_d = mem_fault_q | (state_d == StFault);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StRun;
      wait_cnt_q  <= 8'd0;
      flush_cnt_q <= 4'd0;
      mem_fault_q <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_fault_q <= mem_fault_d;
      if (pc_hold_c && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign bus.pc_hold      = pc_hold_c;
  assign bus.if_id_hold   = if_id_hold_c;
  assign bus.if_id_flush  = if_id_flush_c;
  assign bus.id_ex_stall  = id_ex_stall_c;
  assign bus.id_ex_hold   = id_ex_hold_c;
  assign bus.ex_mem_hold  = ex_mem_hold_c;
  assign bus.mem_fault    = mem_fault_q;
  assign bus.state        = state_q;
  assign bus.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctl.sv
// tb_hazard_ctl: directed scenarios followed by randomized traffic, each cycle compared against
// a behavioural model of the controller's rules; ends with a stall-counter saturation run.
module tb_hazard_ctl;
  localparam int unsigned FC = 2;
  localparam int unsigned WT = 4;

  // Control vector order: {pc_hold, if_id_hold, if_id_flush, id_ex_stall, id_ex_hold, ex_mem_hold}
  localparam logic [5:0] FREEZE = 6'b110011;
  localparam logic [5:0] BUBBLE = 6'b001100;
  localparam logic [5:0] LUSE   = 6'b110100;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hazard_ctl_if hif ();

  hazard_ctl #(
    .FLUSH_CYCLES(FC),
    .WAIT_TIMEOUT(WT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (hif)
  );

  logic [5:0] ctl_obs;
  assign ctl_obs = {hif.pc_hold, hif.if_id_hold, hif.if_id_flush,
                    hif.id_ex_stall, hif.id_ex_hold, hif.ex_mem_hold};

  int vectors = 0;
  int miscompares = 0;

  // Model: mode 0 run, 1 waiting on memory, 2 flushing, 3 faulted.
  int   m_mode, m_waited, m_left, m_stalls;
  bit   m_fault;
  int   n_mode, n_waited, n_left;
  logic [5:0] e_ctl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    hif.id_valid = 0; hif.id_src_top = 0; hif.id_src_bot = 0;
    hif.id_uses_top = 0; hif.id_uses_bot = 0; hif.ex_load = 0; hif.ex_dest = 0;
    hif.branch_taken = 0; hif.mem_req = 0; hif.mem_ready = 0;
  endtask

  task automatic run_rules(input bit allow_mem, input bit blk, input bit luh);
    if (allow_mem && blk) begin
      e_ctl = FREEZE; n_mode = 1; n_waited = 1;
    end else if (hif.branch_taken) begin
      e_ctl = BUBBLE;
      n_mode = (FC > 1) ? 2 : 0;
      if (FC > 1) n_left = FC - 1;
    end else if (luh) begin
      e_ctl = LUSE; n_mode = 0;
    end else begin
      n_mode = 0;
    end
  endtask

  task automatic model_eval();
    bit blk, luh;
    e_ctl = '0; n_mode = m_mode; n_waited = m_waited; n_left = m_left;
    blk = hif.mem_req && !hif.mem_ready;
    luh = hif.ex_load && hif.id_valid &&
          ((hif.id_uses_top && hif.id_src_top == hif.ex_dest) ||
           (hif.id_uses_bot && hif.id_src_bot == hif.ex_dest));
    if (reset) return;
    case (m_mode)
      0: run_rules(1'b1, blk, luh);
      1: begin
        if (!hif.mem_ready) begin
          e_ctl = FREEZE;
          if (m_waited == WT) n_mode = 3;
          else n_waited = m_waited + 1;
        end else begin
          run_rules(1'b0, blk, luh);
        end
      end
      2: begin
        if (blk) begin
          e_ctl = FREEZE;
        end else begin
          e_ctl = BUBBLE;
          n_left = hif.branch_taken ? FC - 1 : m_left - 1;
          if (n_left == 0) n_mode = 0;
        end
      end
      default: e_ctl = FREEZE;
    endcase
  endtask

  task automatic model_commit();
    if (reset) begin
      m_mode = 0; m_waited = 0; m_left = 0; m_fault = 0; m_stalls = 0;
    end else begin
      if (e_ctl[5] && m_stalls < 65535) m_stalls++;
      m_mode = n_mode; m_waited = n_waited; m_left = n_left;
      if (n_mode == 3) m_fault = 1;
    end
  endtask

  // Inputs are set before the call (just after a rising edge); checks happen on the falling edge.
  task automatic cycle(input string tag);
    model_eval();
    @(negedge clock);
    check({tag, ":ctl"}, 32'(ctl_obs), 32'(e_ctl));
    check({tag, ":state"}, 32'(hif.state), 32'(m_mode));
    check({tag, ":fault"}, 32'(hif.mem_fault), 32'(m_fault));
    check({tag, ":stalls"}, 32'(hif.stall_cycles), 32'(m_stalls));
    @(posedge clock);
    model_commit();
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    m_mode = 0; m_waited = 0; m_left = 0; m_fault = 0; m_stalls = 0;
    @(posedge clock);
    #1;

    // Reset: outputs forced low even with hazard sources active.
    hif.branch_taken = 1; hif.mem_req = 1;
    cycle("reset_forced");
    idle();
    cycle("reset_idle");
    check("reset_state", 32'(hif.state), 32'd0);
    reset = 1'b0;
    cycle("idle");

    // Load-use on the bottom operand: one bubble, one stall cycle.
    hif.ex_load = 1; hif.ex_dest = 5; hif.id_valid = 1; hif.id_uses_bot = 1; hif.id_src_bot = 5;
    cycle("luh");
    check("luh_count", 32'(hif.stall_cycles), 32'd1);
    idle();
    cycle("luh_after");

    // Register 0 has no exemption.
    hif.ex_load = 1; hif.ex_dest = 0; hif.id_valid = 1; hif.id_uses_top = 1; hif.id_src_top = 0;
    cycle("luh_r0");
    idle();

    // Branch: two bubbles, state 0 -> 2 -> 0, PC never held.
    hif.branch_taken = 1;
    cycle("br1");
    check("br_state_flush", 32'(hif.state), 32'd2);
    idle();
    cycle("br2");
    check("br_state_run", 32'(hif.state), 32'd0);

    // Branch and load-use together: branch wins.
    hif.branch_taken = 1; hif.ex_load = 1; hif.ex_dest = 7; hif.id_valid = 1;
    hif.id_uses_top = 1; hif.id_src_top = 7;
    cycle("br_luh");
    idle();
    cycle("br_luh_flush");

    // Memory wait of 3 cycles then ready.
    hif.mem_req = 1; hif.mem_ready = 0;
    for (int i = 0; i < 3; i++) cycle("memwait");
    check("memwait_state", 32'(hif.state), 32'd1);
    hif.mem_ready = 1;
    cycle("mem_release");
    check("memwait_count", 32'(hif.stall_cycles), 32'd5);
    idle();
    cycle("mem_idle");

    // Memory stall inside a flush.
    hif.branch_taken = 1;
    cycle("fl_br");
    hif.branch_taken = 0; hif.mem_req = 1; hif.mem_ready = 0;
    cycle("fl_frz1");
    cycle("fl_frz2");
    hif.mem_ready = 1;
    cycle("fl_last");
    idle();
    check("fl_state", 32'(hif.state), 32'd0);
    cycle("fl_done");

    // Timeout into FAULT, then reset clears it.
    hif.mem_req = 1; hif.mem_ready = 0;
    for (int i = 0; i < WT + 2; i++) cycle("timeout");
    check("fault_state", 32'(hif.state), 32'd3);
    check("fault_flag", 32'(hif.mem_fault), 32'd1);
    idle();
    hif.mem_ready = 1;
    cycle("fault_frozen");
    reset = 1'b1;
    cycle("fault_reset");
    reset = 1'b0;
    check("fault_cleared", 32'(hif.mem_fault), 32'd0);
    idle();
    cycle("post_reset");

    // Randomized traffic with small register indices to make hazards frequent.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 59) == 0) || (m_mode == 3 && $urandom_range(0, 7) == 0);
      hif.id_valid     = 1'($urandom_range(0, 1));
      hif.id_src_top   = 5'($urandom_range(0, 7));
      hif.id_src_bot   = 5'($urandom_range(0, 7));
      hif.id_uses_top  = 1'($urandom_range(0, 1));
      hif.id_uses_bot  = 1'($urandom_range(0, 1));
      hif.ex_load      = 1'($urandom_range(0, 1));
      hif.ex_dest      = 5'($urandom_range(0, 7));
      hif.branch_taken = ($urandom_range(0, 5) == 0);
      hif.mem_req      = ($urandom_range(0, 3) == 0);
      hif.mem_ready    = 1'($urandom_range(0, 1));
      cycle("rand");
    end

    // Saturation: park in FAULT so pc_hold stays high past 65535 cycles.
    idle();
    reset = 1'b1;
    cycle("sat_reset");
    reset = 1'b0;
    hif.mem_req = 1; hif.mem_ready = 0;
    for (int i = 0; i < 65540; i++) cycle("sat");
    check("sat_value", 32'(hif.stall_cycles), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
